// File: rtl/data_ram_responder.sv
// data_ram_responder: single-outstanding load/store responder for a word-organised data RAM
module data_ram_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        busReq,
  input  logic        busWe,
  input  logic [31:0] busAddr,
  input  logic [31:0] busWData,
  input  logic [2:0]  strb,
  output logic [31:0] busRData,
  output logic        busReady,
  output logic        busErr,
  output logic        busBusy
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;
  localparam logic [3:0] WC_M1 = 4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);
  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    we_q, err_q, err_d, err;
  logic [31:0]             addr_q, wdata_q, rdata_q, rdata_d, rd_word, ld, wr_data;
  logic [2:0]              strb_q;
  logic [3:0]              be;
  logic [7:0]              byte_v;
  logic [15:0]             half_v;
  logic                    is_half, is_word, bad_strb, wr_en;
  logic [ADDR_WIDTH-1:0]   word_idx;
  logic [31:0]             mem [0:(1<<ADDR_WIDTH)-1];
  // state, wait counter, latched request and registered response
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (state_q == S_IDLE && busReq) begin
        we_q    <= busWe;
        addr_q  <= busAddr;
        wdata_q <= busWData;
        strb_q  <= strb;
      end
    end
  end
  // next state: idle -> optional wait countdown -> access -> one-cycle response
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (busReq) begin
        state_d = WAIT_CYCLES > 0 ? S_WAIT : S_ACCESS;
        cnt_d   = WC_M1;
      end
      S_WAIT: begin
        state_d = cnt_q == 4'd0 ? S_ACCESS : S_WAIT;
        cnt_d   = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
      end
      S_ACCESS: state_d = S_RESP;
      default:  state_d = S_IDLE;
    endcase
  end
  // request checking, lane selection and load extension on the latched request
  always_comb begin
    word_idx = addr_q[ADDR_WIDTH+1:2];
    rd_word  = mem[word_idx];
    is_half  = strb_q[1:0] == 2'b01;
    is_word  = strb_q == 3'b010;
    bad_strb = strb_q == 3'b011 || strb_q[2:1] == 2'b11;
    err      = ((addr_q >> (ADDR_WIDTH + 2)) != '0) || bad_strb || (is_half && addr_q[0]) ||
               (is_word && addr_q[1:0] != 2'b00) || (we_q && strb_q[2]);
    byte_v   = rd_word[{addr_q[1:0], 3'b000} +: 8];
    half_v   = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    ld       = strb_q[1:0] == 2'b00 ? {{24{~strb_q[2] & byte_v[7]}}, byte_v} :
               strb_q[1:0] == 2'b01 ? {{16{~strb_q[2] & half_v[15]}}, half_v} : rd_word;
    be       = strb_q[1:0] == 2'b00 ? 4'b0001 << addr_q[1:0] :
               strb_q[1:0] == 2'b01 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wr_data  = strb_q[1:0] == 2'b00 ? {4{wdata_q[7:0]}} :
               strb_q[1:0] == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
    wr_en    = state_q == S_ACCESS && reset && we_q && !err;
    rdata_d  = state_q == S_ACCESS ? ((we_q || err) ? 32'd0 : ld) : rdata_q;
    err_d    = state_q == S_ACCESS ? err : err_q;
  end
  // byte-enabled RAM write, untouched by reset
  always_ff @(posedge clk) begin
    if (wr_en)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
  end
  // outputs decoded from registered state only
  always_comb begin
    busBusy  = state_q != S_IDLE;
    busReady = state_q == S_RESP;
    busErr   = busReady && err_q;
    busRData = rdata_q;
  end
endmodule

// File: tb/tb_data_ram_responder.sv
// tb_data_ram_responder: vector table plus scoreboard bench for data_ram_responder
module tb_data_ram_responder;
  logic        clk = 0, reset = 0, we = 0, req0 = 0, req3 = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic [2:0]  strb = 0;
  logic [31:0] rd0, rd3;
  logic        rdy0, err0, busy0, rdy3, err3, busy3;
  int          total = 0, bad = 0;
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  strb;
    logic [31:0] exp;
    logic        exp_err;
  } vec_t;
  typedef struct {
    logic [31:0] d;
    logic        e;
  } exp_t;
  exp_t sb[$];
  vec_t tbl[29];

  always #5 clk = ~clk;

  data_ram_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .reset(reset), .busReq(req0), .busWe(we), .busAddr(addr), .busWData(wdata),
    .strb(strb), .busRData(rd0), .busReady(rdy0), .busErr(err0), .busBusy(busy0));
  data_ram_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(3)) u3 (
    .clk(clk), .reset(reset), .busReq(req3), .busWe(we), .busAddr(addr), .busWData(wdata),
    .strb(strb), .busRData(rd3), .busReady(rdy3), .busErr(err3), .busBusy(busy3));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic set_in(input vec_t v);
    we = v.we; addr = v.addr; wdata = v.wdata; strb = v.strb;
    sb.push_back('{v.exp, v.exp_err});
  endtask

  task automatic txn(input string nm, input bit d3, input vec_t v, input bit poke);
    int   n;
    bit   got;
    exp_t e;
    @(negedge clk);
    set_in(v);
    if (d3) req3 = 1; else req0 = 1;
    @(posedge clk);
    got = 0;
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) begin req0 = 0; req3 = 0; end
      if (poke && n == 2) req3 = 1;
      if (poke && n == 3) req3 = 0;
      if (d3 ? rdy3 : rdy0) begin got = 1; break; end
      chk({nm, " busy"}, 32'(d3 ? busy3 : busy0), 32'd1);
    end
    chk({nm, " latency"}, 32'(n), d3 ? 32'd5 : 32'd2);
    e = sb.pop_front();
    if (got) begin
      chk({nm, " data"}, d3 ? rd3 : rd0, e.d);
      chk({nm, " err"}, 32'(d3 ? err3 : err0), 32'(e.e));
      chk({nm, " busy@ready"}, 32'(d3 ? busy3 : busy0), 32'd1);
      @(negedge clk);
      chk({nm, " ready pulse"}, 32'(d3 ? rdy3 : rdy0), 32'd0);
      chk({nm, " idle after"}, 32'(d3 ? busy3 : busy0), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    int   got, n;
    exp_t e;
    tbl[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 3'b010, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 32'h10,   32'h0,        3'b010, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 32'h20,   32'h11223344, 3'b010, 32'h0,        1'b0};
    tbl[3]  = '{1'b1, 32'h21,   32'h000000A5, 3'b000, 32'h0,        1'b0};
    tbl[4]  = '{1'b0, 32'h20,   32'h0,        3'b010, 32'h1122A544, 1'b0};
    tbl[5]  = '{1'b0, 32'h21,   32'h0,        3'b000, 32'hFFFFFFA5, 1'b0};
    tbl[6]  = '{1'b0, 32'h21,   32'h0,        3'b100, 32'h000000A5, 1'b0};
    tbl[7]  = '{1'b1, 32'h22,   32'h00008001, 3'b001, 32'h0,        1'b0};
    tbl[8]  = '{1'b0, 32'h22,   32'h0,        3'b001, 32'hFFFF8001, 1'b0};
    tbl[9]  = '{1'b0, 32'h22,   32'h0,        3'b101, 32'h00008001, 1'b0};
    tbl[10] = '{1'b0, 32'h20,   32'h0,        3'b010, 32'h8001A544, 1'b0};
    tbl[11] = '{1'b0, 32'h23,   32'h0,        3'b000, 32'hFFFFFF80, 1'b0};
    tbl[12] = '{1'b0, 32'h20,   32'h0,        3'b001, 32'hFFFFA544, 1'b0};
    tbl[13] = '{1'b0, 32'h20,   32'h0,        3'b100, 32'h00000044, 1'b0};
    tbl[14] = '{1'b1, 32'h14,   32'h55667788, 3'b010, 32'h0,        1'b0};
    tbl[15] = '{1'b1, 32'h0,    32'hCAFEF00D, 3'b010, 32'h0,        1'b0};
    tbl[16] = '{1'b1, 32'h30,   32'h0,        3'b010, 32'h0,        1'b0};
    tbl[17] = '{1'b0, 32'h13,   32'h0,        3'b010, 32'h0,        1'b1};
    tbl[18] = '{1'b1, 32'h15,   32'h0000FFFF, 3'b001, 32'h0,        1'b1};
    tbl[19] = '{1'b0, 32'h14,   32'h0,        3'b010, 32'h55667788, 1'b0};
    tbl[20] = '{1'b1, 32'h1000, 32'h12345678, 3'b010, 32'h0,        1'b1};
    tbl[21] = '{1'b0, 32'h0,    32'h0,        3'b010, 32'hCAFEF00D, 1'b0};
    tbl[22] = '{1'b0, 32'h10,   32'h0,        3'b011, 32'h0,        1'b1};
    tbl[23] = '{1'b1, 32'h10,   32'h0,        3'b011, 32'h0,        1'b1};
    tbl[24] = '{1'b1, 32'h10,   32'h0,        3'b100, 32'h0,        1'b1};
    tbl[25] = '{1'b1, 32'h10,   32'h0,        3'b110, 32'h0,        1'b1};
    tbl[26] = '{1'b0, 32'h10,   32'h0,        3'b111, 32'h0,        1'b1};
    tbl[27] = '{1'b0, 32'h10,   32'h0,        3'b010, 32'hDEADBEEF, 1'b0};
    tbl[28] = '{1'b0, 32'h400,  32'h0,        3'b010, 32'h0,        1'b1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst ready0", 32'(rdy0), 0); chk("rst err0", 32'(err0), 0);
    chk("rst busy0", 32'(busy0), 0); chk("rst data0", rd0, 0);
    chk("rst ready3", 32'(rdy3), 0); chk("rst busy3", 32'(busy3), 0);
    reset = 1;

    foreach (tbl[i]) txn($sformatf("vec%0d", i), 1'b0, tbl[i], 1'b0);

    txn("w3 sw", 1'b1, '{1'b1, 32'h8, 32'h12345678, 3'b010, 32'h0, 1'b0}, 1'b0);
    txn("w3 lw", 1'b1, '{1'b0, 32'h8, 32'h0, 3'b010, 32'h12345678, 1'b0}, 1'b1);
    got = 0;
    repeat (10) begin
      @(negedge clk);
      if (rdy3) got++;
    end
    chk("w3 ignored req", 32'(got), 0);

    @(negedge clk);
    we = 1; addr = 32'h30; wdata = 32'hFFFFFFFF; strb = 3'b010; req0 = 1;
    @(posedge clk);
    @(negedge clk);
    req0 = 0;
    chk("rstacc busy", 32'(busy0), 1);
    reset = 0;
    @(posedge clk);
    @(negedge clk);
    chk("rstacc busy after", 32'(busy0), 0);
    chk("rstacc ready after", 32'(rdy0), 0);
    reset = 1;
    got = 0;
    repeat (4) begin
      @(negedge clk);
      if (rdy0) got++;
    end
    chk("rstacc no ready", 32'(got), 0);
    txn("rstacc lw", 1'b0, '{1'b0, 32'h30, 32'h0, 3'b010, 32'h0, 1'b0}, 1'b0);

    @(negedge clk);
    we = 1; addr = 32'h30; wdata = 32'h77777777; strb = 3'b010; req0 = 1; reset = 0;
    @(posedge clk);
    @(negedge clk);
    req0 = 0; reset = 1;
    chk("rstreq busy", 32'(busy0), 0);
    txn("rstreq lw", 1'b0, '{1'b0, 32'h30, 32'h0, 3'b010, 32'h0, 1'b0}, 1'b0);

    @(negedge clk);
    v = '{1'b1, 32'h40, 32'hA0000000, 3'b010, 32'h0, 1'b0};
    set_in(v);
    req0 = 1;
    got = 0;
    for (n = 1; n <= 40 && got < 8; n++) begin
      @(negedge clk);
      if (rdy0) begin
        chk($sformatf("held %0d spacing", got), 32'(n), 32'(2 + 3 * got));
        e = sb.pop_front();
        chk($sformatf("held %0d data", got), rd0, e.d);
        chk($sformatf("held %0d err", got), 32'(err0), 32'(e.e));
        got++;
        if (got == 8) req0 = 0;
        else if (got % 2 == 1) set_in('{1'b0, 32'h40, 32'h0, 3'b010, 32'hA0000000 + 32'(got - 1), 1'b0});
        else set_in('{1'b1, 32'h40, 32'hA0000000 + 32'(got), 3'b010, 32'h0, 1'b0});
      end
    end
    req0 = 0;
    chk("held count", 32'(got), 32'd8);
    sb.delete();
    repeat (5) @(negedge clk);
    chk("held idle", 32'(busy0), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
